// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
// The master side feeds values and consumes results; the slave side is the converter.
interface bin_to_bcd_seq_if #(
  parameter int IN_W = 8,
  parameter int NDIG = 3
);
  logic                in_valid;
  logic                in_ready;
  logic [IN_W-1:0]     data_in;
  logic                out_valid;
  logic                out_ready;
  logic [4*NDIG-1:0]   bcd_out;
  logic                ovf;
  logic [NDIG-1:0]     blank_mask;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, bcd_out, ovf, blank_mask
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, bcd_out, ovf, blank_mask
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Double-dabble binary-to-BCD converter, one input bit per clock; result valid IN_W edges after accept.
// No input queue: in_ready only in IDLE; result held in DONE until out_ready handshake.
module bin_to_bcd_seq #(
  parameter int IN_W = 8,
  parameter int NDIG = 3
) (
  input  logic            clk,
  input  logic            rst,
  bin_to_bcd_seq_if.slave bus
);
  localparam int BCD_W = 4 * NDIG;
  localparam int CNT_W = $clog2(IN_W + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [IN_W-1:0]  bin_sr;
  logic [BCD_W-1:0] acc;
  logic [BCD_W-1:0] acc_adj;
  logic [BCD_W-1:0] acc_nxt;
  logic [BCD_W-1:0] bcd_q;
  logic             ovf_acc;
  logic             ovf_q;
  logic             carry_out;
  logic             last_shift;
  logic             hi_zero;
  logic [NDIG-1:0]  blank;

  // Add-3 per digit is local to each nibble; no carry crosses digit boundaries.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < NDIG; i++) begin
      if (acc[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    {carry_out, acc_nxt} = {acc_adj, bin_sr[IN_W-1]};
  end

  assign last_shift = (cnt == CNT_W'(IN_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bin_sr  <= '0;
      acc     <= '0;
      ovf_acc <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bin_sr  <= bus.data_in;
            acc     <= '0;
            ovf_acc <= 1'b0;
            cnt     <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          acc     <= acc_nxt;
          bin_sr  <= bin_sr << 1;
          ovf_acc <= ovf_acc | carry_out;
          cnt     <= cnt + 1'b1;
          // Output register only moves here, so bcd_out survives the handshake.
          if (last_shift) begin
            bcd_q <= acc_nxt;
            ovf_q <= ovf_acc | carry_out;
            cnt   <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bit i blanks when digit i and every digit above it are zero; units never blank.
  always_comb begin
    blank   = '0;
    hi_zero = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      hi_zero  = hi_zero & (bcd_q[4*i +: 4] == 4'd0);
      blank[i] = hi_zero;
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.bcd_out    = bcd_q;
  assign bus.ovf        = ovf_q;
  assign bus.blank_mask = blank;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and sweep bench for bin_to_bcd_seq with a 3-digit and a 2-digit instance fed in lockstep.
module tb_bin_to_bcd_seq;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.IN_W(8), .NDIG(3)) b3();
  bin_to_bcd_seq_if #(.IN_W(8), .NDIG(2)) b2();

  bin_to_bcd_seq #(.IN_W(8), .NDIG(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b3));
  bin_to_bcd_seq #(.IN_W(8), .NDIG(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));

  task automatic drive(input logic vld, input logic [7:0] d, input logic ordy);
    b3.in_valid = vld; b3.data_in = d; b3.out_ready = ordy;
    b2.in_valid = vld; b2.data_in = d; b2.out_ready = ordy;
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    drive(1'b1, d, 1'b0);
    @(negedge clk);
    drive(1'b0, d, 1'b0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (b3.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (b3.out_valid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_done: out_valid=%b still low after %0d cycles", b3.out_valid, lat);
    end
  endtask

  task automatic pop();
    b3.out_ready = 1'b1; b2.out_ready = 1'b1;
    @(negedge clk);
    b3.out_ready = 1'b0; b2.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 8'd0, 1'b0);
    #2 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (b3.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", b3.out_valid); end
    checks++; if (b3.bcd_out !== 12'h000) begin errors++; $display("FAIL reset_bcd: got %h expected 000", b3.bcd_out); end
    checks++; if (b3.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", b3.ovf); end
    checks++; if (b2.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid2: got %b expected 0", b2.out_valid); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (b3.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", b3.in_ready); end
  endtask

  task automatic test_max();
    int lat;
    send(8'd255);
    lat = 0;
    while (b3.out_valid !== 1'b1 && lat < 40) begin
      checks++;
      if (b3.in_ready !== 1'b0) begin errors++; $display("FAIL max_in_ready_busy: got %b expected 0 at cycle %0d", b3.in_ready, lat); end
      @(negedge clk);
      lat++;
    end
    checks++; if (lat != 8) begin errors++; $display("FAIL max_latency: got %0d expected 8", lat); end
    checks++; if (b3.bcd_out !== 12'h255) begin errors++; $display("FAIL max_bcd: got %h expected 255", b3.bcd_out); end
    checks++; if (b3.ovf !== 1'b0) begin errors++; $display("FAIL max_ovf: got %b expected 0", b3.ovf); end
    checks++; if (b3.blank_mask !== 3'b000) begin errors++; $display("FAIL max_mask: got %b expected 000", b3.blank_mask); end
    pop();
  endtask

  task automatic test_small();
    logic [7:0]  vals [3] = '{8'd0, 8'd7, 8'd42};
    logic [11:0] exp_b[3] = '{12'h000, 12'h007, 12'h042};
    logic [2:0]  exp_m[3] = '{3'b110, 3'b110, 3'b100};
    int lat;
    for (int k = 0; k < 3; k++) begin
      send(vals[k]);
      wait_done(lat);
      checks++; if (b3.bcd_out !== exp_b[k]) begin errors++; $display("FAIL small_bcd[%0d]: got %h expected %h", vals[k], b3.bcd_out, exp_b[k]); end
      checks++; if (b3.blank_mask !== exp_m[k]) begin errors++; $display("FAIL small_mask[%0d]: got %b expected %b", vals[k], b3.blank_mask, exp_m[k]); end
      pop();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send(8'd128);
    wait_done(lat);
    drive(1'b1, 8'd9, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (b3.bcd_out !== 12'h128 || b3.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold: got %h valid %b expected 128 valid 1", b3.bcd_out, b3.out_valid); end
      checks++; if (b3.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", b3.in_ready); end
    end
    b3.out_ready = 1'b1; b2.out_ready = 1'b1;
    @(negedge clk);
    b3.out_ready = 1'b0; b2.out_ready = 1'b0;
    checks++; if (b3.in_ready !== 1'b1 || b3.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: in_ready %b out_valid %b expected 1 0", b3.in_ready, b3.out_valid); end
    checks++; if (b3.bcd_out !== 12'h128) begin errors++; $display("FAIL bp_result_kept: got %h expected 128", b3.bcd_out); end
    @(negedge clk);
    drive(1'b0, 8'd0, 1'b0);
    wait_done(lat);
    checks++; if (lat != 8) begin errors++; $display("FAIL bp_second_latency: got %0d expected 8", lat); end
    checks++; if (b3.bcd_out !== 12'h009) begin errors++; $display("FAIL bp_second_bcd: got %h expected 009", b3.bcd_out); end
    pop();
  endtask

  task automatic test_overflow();
    logic [7:0] vals [3] = '{8'd200, 8'd199, 8'd99};
    logic [7:0] exp_b[3] = '{8'h00, 8'h99, 8'h99};
    logic       exp_o[3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0] exp_m[3] = '{2'b10, 2'b00, 2'b00};
    int lat;
    for (int k = 0; k < 3; k++) begin
      send(vals[k]);
      wait_done(lat);
      checks++; if (b2.bcd_out !== exp_b[k]) begin errors++; $display("FAIL ovf_bcd[%0d]: got %h expected %h", vals[k], b2.bcd_out, exp_b[k]); end
      checks++; if (b2.ovf !== exp_o[k]) begin errors++; $display("FAIL ovf_flag[%0d]: got %b expected %b", vals[k], b2.ovf, exp_o[k]); end
      checks++; if (b2.blank_mask !== exp_m[k]) begin errors++; $display("FAIL ovf_mask[%0d]: got %b expected %b", vals[k], b2.blank_mask, exp_m[k]); end
      pop();
    end
  endtask

  task automatic test_reset_mid();
    int   lat;
    logic seen;
    send(8'd173);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (b3.out_valid !== 1'b0 || b3.bcd_out !== 12'h000) begin errors++; $display("FAIL midrst_state: valid %b bcd %h expected 0 000", b3.out_valid, b3.bcd_out); end
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (b3.out_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_valid: saw out_valid %b expected 0", seen); end
    send(8'd99);
    wait_done(lat);
    checks++; if (b3.bcd_out !== 12'h099) begin errors++; $display("FAIL midrst_next_bcd: got %h expected 099", b3.bcd_out); end
    checks++; if (b3.blank_mask !== 3'b100) begin errors++; $display("FAIL midrst_next_mask: got %b expected 100", b3.blank_mask); end
    pop();
  endtask

  task automatic test_sweep();
    int lat, d0, d1, d2;
    logic [11:0] e3;
    logic [7:0]  e2;
    logic [2:0]  m3;
    logic [1:0]  m2;
    for (int v = 0; v < 256; v++) begin
      d0 = v % 10; d1 = (v / 10) % 10; d2 = (v / 100) % 10;
      e3 = 12'(d2 * 256 + d1 * 16 + d0);
      e2 = 8'(d1 * 16 + d0);
      m3 = {d2 == 0, (d2 == 0) && (d1 == 0), 1'b0};
      m2 = {d1 == 0, 1'b0};
      send(8'(v));
      lat = 0;
      while (b3.out_valid !== 1'b1 && lat < 40) begin
        b3.out_ready = 1'($urandom_range(0, 1));
        b2.out_ready = b3.out_ready;
        @(negedge clk);
        lat++;
      end
      b3.out_ready = 1'b0; b2.out_ready = 1'b0;
      checks++; if (lat != 8) begin errors++; $display("FAIL sweep_latency[%0d]: got %0d expected 8", v, lat); end
      checks++; if (b3.bcd_out !== e3 || b3.ovf !== 1'b0 || b3.blank_mask !== m3) begin errors++; $display("FAIL sweep3[%0d]: got %h/%b/%b expected %h/0/%b", v, b3.bcd_out, b3.ovf, b3.blank_mask, e3, m3); end
      checks++; if (b2.bcd_out !== e2 || b2.ovf !== (v >= 100) || b2.blank_mask !== m2) begin errors++; $display("FAIL sweep2[%0d]: got %h/%b/%b expected %h/%b/%b", v, b2.bcd_out, b2.ovf, b2.blank_mask, e2, v >= 100, m2); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      checks++; if (b3.out_valid !== 1'b1 || b3.bcd_out !== e3) begin errors++; $display("FAIL sweep_stall[%0d]: valid %b bcd %h expected 1 %h", v, b3.out_valid, b3.bcd_out, e3); end
      pop();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_max();
    test_small();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
